// File: rtl/scanner_pkg.sv
// Shared scanner link definitions: command codes, word width and
// receiver FSM encoding, common to transmitter and receiver.
package scanner_pkg;

   localparam int WORD_W = 8;

   localparam logic [WORD_W-1:0] CMD_READY_XFER = 8'd2;
   localparam logic [WORD_W-1:0] CMD_START_SCAN = 8'd3;
   localparam logic [WORD_W-1:0] CMD_FULL       = 8'd4;
   localparam logic [WORD_W-1:0] CMD_XFER_DATA  = 8'd7;

   typedef enum logic {
      WAIT_CMD  = 1'b0,
      WAIT_DATA = 1'b1
   } rx_state_t;

endpackage

// File: rtl/serial_word_deser.sv
// Oversampling deserialiser: synchronises the scanner serial link,
// assembles MSB-first words and drops stalled partial words.
module serial_word_deser
   import scanner_pkg::*;
#(
   parameter int TIMEOUT = 16,
   parameter int SYNC    = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ser_clk,
   input  logic              ser_data,
   output logic              word_done,
   output logic [WORD_W-1:0] word,
   output logic              timeout_err
);

   localparam int TW = $clog2(TIMEOUT + 1);

   logic [SYNC-1:0]   clk_sync;
   logic [SYNC-1:0]   data_sync;
   logic              clk_prev;
   logic [WORD_W-1:0] sh_reg;
   logic [2:0]        bit_cnt;
   logic [TW-1:0]     to_cnt;
   logic              strobe;
   logic              bit_s;

   assign strobe      = clk_sync[SYNC-1] & ~clk_prev;
   assign bit_s       = data_sync[SYNC-1];
   assign word        = {sh_reg[WORD_W-2:0], bit_s};
   assign word_done   = strobe && (bit_cnt == 3'd7);
   // A strobe in the expiry cycle keeps the word alive
   assign timeout_err = !strobe && (bit_cnt != 3'd0) &&
                        (to_cnt == TW'(TIMEOUT - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clk_sync  <= '0;
         data_sync <= '0;
         clk_prev  <= 1'b0;
      end else begin
         clk_sync  <= {clk_sync[SYNC-2:0], ser_clk};
         data_sync <= {data_sync[SYNC-2:0], ser_data};
         clk_prev  <= clk_sync[SYNC-1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sh_reg  <= '0;
         bit_cnt <= 3'd0;
         to_cnt  <= '0;
      end else if (strobe) begin
         sh_reg  <= word;
         bit_cnt <= bit_cnt + 3'd1;
         to_cnt  <= '0;
      end else if (timeout_err) begin
         bit_cnt <= 3'd0;
         to_cnt  <= '0;
      end else if (bit_cnt != 3'd0) begin
         to_cnt  <= to_cnt + TW'(1);
      end else begin
         to_cnt  <= '0;
      end
   end

endmodule

// File: rtl/scanner_receiver.sv
// Scanner link receiver: decodes command/data words, keeps status
// flags and drives the transfer-ready handshake back to the scanner.
module scanner_receiver
   import scanner_pkg::*;
#(
   parameter int TIMEOUT = 16,
   parameter int SYNC    = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              serClkIn,
   input  logic              serDataIn,
   input  logic              sinkReady,
   output logic              readyForTransferOut,
   output logic              cmdValid,
   output logic [WORD_W-1:0] cmdCode,
   output logic              dataValid,
   output logic [WORD_W-1:0] dataWord,
   output logic              scanning,
   output logic              xferPending,
   output logic              bufferFull,
   output logic              linkErr
);

   rx_state_t         state, state_n;
   logic              word_done;
   logic [WORD_W-1:0] word;
   logic              timeout_err;
   logic              cmd_v, data_v, err;
   logic [WORD_W-1:0] code_n, dw_n;
   logic              scan_n, xfer_n, full_n;

   serial_word_deser #(
      .TIMEOUT (TIMEOUT),
      .SYNC    (SYNC)
   ) u_deser (
      .clk         (clk),
      .rst         (rst),
      .ser_clk     (serClkIn),
      .ser_data    (serDataIn),
      .word_done   (word_done),
      .word        (word),
      .timeout_err (timeout_err)
   );

   always_comb begin
      state_n = state;
      cmd_v   = 1'b0;
      data_v  = 1'b0;
      err     = 1'b0;
      code_n  = cmdCode;
      dw_n    = dataWord;
      scan_n  = scanning;
      xfer_n  = xferPending;
      full_n  = bufferFull;
      if (timeout_err) begin
         err     = 1'b1;
         state_n = WAIT_CMD;
      end else if (word_done) begin
         case (state)
            WAIT_CMD: begin
               cmd_v  = 1'b1;
               code_n = word;
               case (word)
                  CMD_XFER_DATA:  state_n = WAIT_DATA;
                  CMD_READY_XFER: xfer_n  = 1'b1;
                  CMD_START_SCAN: scan_n  = 1'b1;
                  CMD_FULL: begin
                     scan_n = 1'b0;
                     full_n = 1'b1;
                  end
                  default:        err     = 1'b1;
               endcase
            end
            WAIT_DATA: begin
               data_v  = 1'b1;
               dw_n    = word;
               xfer_n  = 1'b0;
               full_n  = 1'b0;
               state_n = WAIT_CMD;
            end
            default: state_n = WAIT_CMD;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state               <= WAIT_CMD;
         readyForTransferOut <= 1'b0;
         cmdValid            <= 1'b0;
         cmdCode             <= '0;
         dataValid           <= 1'b0;
         dataWord            <= '0;
         scanning            <= 1'b0;
         xferPending         <= 1'b0;
         bufferFull          <= 1'b0;
         linkErr             <= 1'b0;
      end else begin
         state               <= state_n;
         readyForTransferOut <= sinkReady && (state == WAIT_CMD);
         cmdValid            <= cmd_v;
         cmdCode             <= code_n;
         dataValid           <= data_v;
         dataWord            <= dw_n;
         scanning            <= scan_n;
         xferPending         <= xfer_n;
         bufferFull          <= full_n;
         linkErr             <= err;
      end
   end

endmodule
